// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit and the
// HI/LO forwarding path that consumes its result.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Destination code that steers EX_MEM_prod into the HI/LO forwarding mux.
    localparam logic [5:0] HILO_DEST = 6'd34;

    // Per-instruction control captured at acceptance.
    typedef struct packed {
        logic [1:0] op;
        logic       sign_a;
        logic       sign_b;
        logic       div_zero;
    } md_ctl_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Turns the unsigned magnitude result into the architectural HI/LO value:
// sign correction for MULT/DIV and the all-ones quotient on a zero divisor.
module muldiv_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] raw,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic [1:0]        op,
    input  logic              div_zero,
    output logic [2*XLEN-1:0] result
);
    import muldiv_pkg::*;

    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;

    always_comb begin
        q      = raw[XLEN-1:0];
        r      = raw[2*XLEN-1:XLEN];
        result = raw;
        case (op)
            MD_MULT: begin
                if (sign_a ^ sign_b) result = -raw;
            end
            MD_DIV: begin
                // Remainder follows the dividend, so a zero divisor returns a unchanged.
                if (div_zero)             q = '1;
                else if (sign_a ^ sign_b) q = -q;
                if (sign_a)               r = -r;
                result = {r, q};
            end
            MD_DIVU: begin
                if (div_zero) q = '1;
                result = {r, q};
            end
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU for the EX stage; stalls the front of
// the pipeline for XLEN+1 cycles and presents {HI,LO} on prod with done.
module muldiv_unit #(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              stall_req,
    output logic [2*XLEN-1:0] prod
);
    import muldiv_pkg::*;

    localparam int CW = $clog2(XLEN);

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    md_ctl_t           ctl;
    logic [XLEN-1:0]   opd;
    logic [2*XLEN-1:0] acc;
    logic [XLEN:0]     rem;
    logic [XLEN-1:0]   quo;

    logic              is_signed;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN+1:0]   div_shift;
    logic [XLEN+1:0]   div_trial;
    logic [XLEN:0]     rem_nxt;
    logic [XLEN-1:0]   quo_nxt;
    logic [2*XLEN-1:0] raw;
    logic [2*XLEN-1:0] fixed;

    assign is_signed = (op == MD_MULT) || (op == MD_DIV);
    assign sa        = is_signed & a[XLEN-1];
    assign sb        = is_signed & b[XLEN-1];
    assign mag_a     = sa ? -a : a;
    assign mag_b     = sb ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opd : '0)};
    assign acc_nxt = {mul_sum, acc[XLEN-1:1]};

    // Divide: restoring step; the top bit of the trial difference is the borrow.
    assign div_shift = {rem, quo[XLEN-1]};
    assign div_trial = div_shift - {2'b00, opd};
    assign rem_nxt   = div_trial[XLEN+1] ? div_shift[XLEN:0] : div_trial[XLEN:0];
    assign quo_nxt   = {quo[XLEN-2:0], ~div_trial[XLEN+1]};

    assign raw = ctl.op[1] ? {rem_nxt[XLEN-1:0], quo_nxt} : acc_nxt;

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .raw      (raw),
        .sign_a   (ctl.sign_a),
        .sign_b   (ctl.sign_b),
        .op       (ctl.op),
        .div_zero (ctl.div_zero),
        .result   (fixed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ctl   <= '0;
            opd   <= '0;
            acc   <= '0;
            rem   <= '0;
            quo   <= '0;
            prod  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        ctl.op       <= op;
                        ctl.sign_a   <= sa;
                        ctl.sign_b   <= sb;
                        ctl.div_zero <= (b == '0);
                        opd          <= op[1] ? mag_b : mag_a;
                        acc          <= {{XLEN{1'b0}}, mag_b};
                        quo          <= mag_a;
                        rem          <= '0;
                        cnt          <= CW'(XLEN - 1);
                        state        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= acc_nxt;
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        if (cnt == '0) begin
                            prod  <= fixed;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                // start is still high here for the same instruction; never re-accept it.
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state == ST_RUN);
    assign stall_req = rst_n & (((state == ST_IDLE) & start & ~flush) | (state == ST_RUN));

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for results and latency, plus
// hand sequences for flush, idle-flush blocking and asynchronous reset in RUN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        stall_req;
    logic [63:0] prod;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[12];

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .stall_req (stall_req),
        .prod      (prod)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issue one instruction, hold start until done, scramble a/b after acceptance.
    task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [63:0] exp, input string nm);
        int dc;
        int sc;
        int c;
        @(posedge clk); #1;
        op = o; a = va; b = vb; start = 1'b1;
        dc = -1; sc = 0; c = 0;
        while (c < 40 && dc < 0) begin
            #1;
            if (stall_req) sc++;
            if (done) dc = c;
            if (c == 2) begin
                a = ~va;
                b = vb + 32'd1;
            end
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        #1;
        chk({nm, " done cycle"}, 64'(dc), 64'd33);
        chk({nm, " stall cycles"}, 64'(sc), 64'd33);
        chk({nm, " prod"}, prod, exp);
        chk({nm, " done after"}, {63'd0, done}, 64'd0);
        chk({nm, " busy after"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB};
        vecs[2]  = '{MD_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000};
        vecs[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD};
        vecs[4]  = '{MD_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E};
        vecs[5]  = '{MD_DIVU,  32'h00001234, 32'h00000000, 64'h00001234_FFFFFFFF};
        vecs[6]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
        vecs[7]  = '{MD_MULTU, 32'd3,        32'd5,        64'h00000000_0000000F};
        vecs[8]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
        vecs[9]  = '{MD_DIV,   32'hFFFFFFF8, 32'h00000000, 64'hFFFFFFF8_FFFFFFFF};
        vecs[10] = '{MD_MULT,  32'd0,        32'hFFFFFFFB, 64'h00000000_00000000};
        vecs[11] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};

        rst_n = 1'b0; start = 1'b1; flush = 1'b0; op = MD_MULTU; a = 32'd3; b = 32'd3;
        #3;
        chk("reset busy",  {63'd0, busy},      64'd0);
        chk("reset done",  {63'd0, done},      64'd0);
        chk("reset stall", {63'd0, stall_req}, 64'd0);
        chk("reset prod",  prod,               64'd0);
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // Flush in RUN cycle 10: no done, prod kept, next start runs normally.
        run_op(MD_MULTU, 32'h11, 32'h1, 64'h11, "preflush");
        @(posedge clk); #1;
        op = MD_MULT; a = 32'd5; b = 32'd6; start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("flush busy before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        #1;
        chk("flush busy",  {63'd0, busy},      64'd0);
        chk("flush stall", {63'd0, stall_req}, 64'd0);
        chk("flush done",  {63'd0, done},      64'd0);
        chk("flush prod",  prod,               64'h11);
        run_op(MD_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, "postflush");

        // Flush in IDLE blocks acceptance even with start high.
        @(posedge clk); #1;
        op = MD_MULTU; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
        #1;
        chk("idle flush stall", {63'd0, stall_req}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        #1;
        chk("idle flush busy", {63'd0, busy}, 64'd0);
        chk("idle flush prod", prod, 64'h00000002_0000000E);

        // Asynchronous reset while in RUN.
        @(posedge clk); #1;
        op = MD_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("rst run busy", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async busy",  {63'd0, busy},      64'd0);
        chk("rst async stall", {63'd0, stall_req}, 64'd0);
        chk("rst async done",  {63'd0, done},      64'd0);
        chk("rst async prod",  prod,               64'd0);
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("post rst busy",  {63'd0, busy},      64'd0);
        chk("post rst stall", {63'd0, stall_req}, 64'd0);
        chk("post rst done",  {63'd0, done},      64'd0);
        chk("post rst prod",  prod,               64'd0);
        run_op(MD_MULTU, 32'd9, 32'd9, 64'd81, "after rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
